// File: rtl/limb_mul_sequencer.sv
// Wide multiplier front end: runs an N x N product through one W x W pipelined
// multiplier, one limb pair per cycle, and sums the shifted partial products.
module limb_mul_sequencer #(
  parameter int W       = 32,
  parameter int LIMBS   = 4,
  parameter int MUL_LAT = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [W*LIMBS-1:0]     a,
  input  logic [W*LIMBS-1:0]     b,
  output logic                   busy,
  output logic [2*W*LIMBS-1:0]   product,
  output logic                   done,
  output logic                   mul_start,
  output logic [W-1:0]           mul_a,
  output logic [W-1:0]           mul_b,
  input  logic [2*W-1:0]         mul_product
);

  localparam int N  = W * LIMBS;
  localparam int IW = (LIMBS > 1) ? $clog2(LIMBS) : 1;
  localparam int SW = $clog2(2 * LIMBS);
  localparam logic [IW-1:0] LAST_IDX = IW'(LIMBS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_FIN
  } state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    a_q, a_d;
  logic [N-1:0]    b_q, b_d;
  logic [IW-1:0]   i_q, i_d;
  logic [IW-1:0]   j_q, j_d;
  logic            mul_start_q, mul_start_d;
  logic [W-1:0]    mul_a_q, mul_a_d;
  logic [W-1:0]    mul_b_q, mul_b_d;
  logic [2*N-1:0]  acc_q, acc_d;
  logic [2*N-1:0]  product_q, product_d;

  logic            tag_v_q [MUL_LAT];
  logic [SW-1:0]   tag_s_q [MUL_LAT];

  logic [W-1:0]    a_limb [LIMBS];
  logic [W-1:0]    b_limb [LIMBS];
  logic [SW-1:0]   s_cur;
  logic            pipe_busy;
  logic [2*N-1:0]  addend;
  logic [2*N-1:0]  acc_add;

  for (genvar gi = 0; gi < LIMBS; gi++) begin : g_limb
    assign a_limb[gi] = a_q[gi*W +: W];
    assign b_limb[gi] = b_q[gi*W +: W];
  end

  // Limb-weight tag travelling with the issue currently on mul_a/mul_b.
  assign s_cur = SW'(i_q) + SW'(j_q);

  for (genvar gi = 0; gi < MUL_LAT; gi++) begin : g_tag
    if (gi == 0) begin : g_head
      always_ff @(posedge clk) begin
        if (rst) begin
          tag_v_q[gi] <= 1'b0;
          tag_s_q[gi] <= '0;
        end else begin
          tag_v_q[gi] <= mul_start_q;
          tag_s_q[gi] <= s_cur;
        end
      end
    end else begin : g_body
      always_ff @(posedge clk) begin
        if (rst) begin
          tag_v_q[gi] <= 1'b0;
          tag_s_q[gi] <= '0;
        end else begin
          tag_v_q[gi] <= tag_v_q[gi-1];
          tag_s_q[gi] <= tag_s_q[gi-1];
        end
      end
    end
  end

  // Anything still upstream of the final tag stage means more products to come.
  always_comb begin
    pipe_busy = 1'b0;
    for (int k = 0; k < MUL_LAT - 1; k++) begin
      pipe_busy = pipe_busy | tag_v_q[k];
    end
  end

  assign addend  = (2*N)'(mul_product) << (W * tag_s_q[MUL_LAT-1]);
  assign acc_add = tag_v_q[MUL_LAT-1] ? (acc_q + addend) : acc_q;

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    i_d         = i_q;
    j_d         = j_q;
    mul_start_d = 1'b0;
    mul_a_d     = '0;
    mul_b_d     = '0;
    acc_d       = acc_add;
    product_d   = product_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d         = a;
          b_d         = b;
          acc_d       = '0;
          i_d         = '0;
          j_d         = '0;
          mul_start_d = 1'b1;
          mul_a_d     = a[W-1:0];
          mul_b_d     = b[W-1:0];
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (i_q == LAST_IDX && j_q == LAST_IDX) begin
          state_d = S_DRAIN;
        end else begin
          if (j_q == LAST_IDX) begin
            i_d = i_q + 1'b1;
            j_d = '0;
          end else begin
            j_d = j_q + 1'b1;
          end
          mul_start_d = 1'b1;
          mul_a_d     = a_limb[i_d];
          mul_b_d     = b_limb[j_d];
        end
      end
      S_DRAIN: begin
        // The last partial product lands on this edge, so capture the sum including it.
        if (!pipe_busy) begin
          product_d = acc_add;
          state_d   = S_FIN;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      i_q         <= '0;
      j_q         <= '0;
      mul_start_q <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      acc_q       <= '0;
      product_q   <= '0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      i_q         <= i_d;
      j_q         <= j_d;
      mul_start_q <= mul_start_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      acc_q       <= acc_d;
      product_q   <= product_d;
    end
  end

  assign busy      = (state_q == S_ISSUE) || (state_q == S_DRAIN);
  assign done      = (state_q == S_FIN);
  assign product   = product_q;
  assign mul_start = mul_start_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;

endmodule

// File: tb/tb_limb_mul_sequencer.sv
// Directed and randomised checks of limb_mul_sequencer against a behavioural
// pipelined W x W multiplier and a full-width reference product.
module tb_limb_mul_sequencer;

  localparam int W       = 32;
  localparam int LIMBS   = 4;
  localparam int MUL_LAT = 2;
  localparam int N       = W * LIMBS;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [N-1:0]     a;
  logic [N-1:0]     b;
  logic             busy;
  logic [2*N-1:0]   product;
  logic             done;
  logic             mul_start;
  logic [W-1:0]     mul_a;
  logic [W-1:0]     mul_b;
  logic [2*W-1:0]   mul_product;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  limb_mul_sequencer #(.W(W), .LIMBS(LIMBS), .MUL_LAT(MUL_LAT)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .product     (product),
    .done        (done),
    .mul_start   (mul_start),
    .mul_a       (mul_a),
    .mul_b       (mul_b),
    .mul_product (mul_product)
  );

  // Behavioural DSP: result of an issue in cycle t is presented in cycle t+MUL_LAT.
  logic [2*W-1:0] mp_q [MUL_LAT];
  always @(posedge clk) begin
    mp_q[0] <= {{W{1'b0}}, mul_a} * {{W{1'b0}}, mul_b};
    for (int k = 1; k < MUL_LAT; k++) mp_q[k] <= mp_q[k-1];
  end
  assign mul_product = mp_q[MUL_LAT-1];

  typedef struct {
    logic [N-1:0]   va;
    logic [N-1:0]   vb;
    logic [2*N-1:0] vexp;
  } vec_t;

  localparam int NVEC = 7;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [2*N-1:0] act, input logic [2*N-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // One operation with a single-cycle start; optional ignored start at cycle extra_cyc.
  task automatic run_op(input logic [N-1:0] va, input logic [N-1:0] vb, input int extra_cyc,
                        output int done_cyc, output int ms_cnt, output int busy_cnt,
                        output logic [2*N-1:0] prod, output logic [2*N-1:0] hold);
    @(negedge clk);
    start    = 1'b1;
    a        = va;
    b        = vb;
    done_cyc = -1;
    ms_cnt   = 0;
    busy_cnt = 0;
    prod     = '0;
    hold     = '0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start = 1'b0;
        hold  = product;
      end
      if (c == extra_cyc) begin
        start = 1'b1;
        a     = 128'd7;
        b     = 128'd7;
      end
      if (c == extra_cyc + 1) start = 1'b0;
      if (mul_start) ms_cnt++;
      if (busy) busy_cnt++;
      if (done) begin
        done_cyc = c;
        prod     = product;
        break;
      end
    end
  endtask

  initial begin
    int dc, msc, bc, done_seen, gap;
    logic [2*N-1:0] pr, hd, exp_prev, rexp;
    logic [N-1:0] ra, rb;

    vecs[0] = '{128'd3, 128'd5, 256'd15};
    vecs[1] = '{128'd1 << 32, (128'd1 << 96) + 128'd1, (256'd1 << 128) + (256'd1 << 32)};
    vecs[2] = '{{128{1'b1}}, {128{1'b1}}, {{124{1'b1}}, 4'hE, 128'd1}};
    vecs[3] = '{128'd0, {128{1'b1}}, 256'd0};
    vecs[4] = '{128'd1 << 96, 128'd1 << 96, 256'd1 << 192};
    vecs[5] = '{128'hFFFF_FFFF, 128'hFFFF_FFFF, 256'hFFFF_FFFE_0000_0001};
    vecs[6] = '{(128'd1 << 64) + 128'd1, (128'd1 << 64) - 128'd1, (256'd1 << 128) - 256'd1};

    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset busy",      256'(busy),      256'd0);
    check("reset done",      256'(done),      256'd0);
    check("reset product",   product,         256'd0);
    check("reset mul_start", 256'(mul_start), 256'd0);
    check("reset mul_a",     256'(mul_a),     256'd0);
    check("reset mul_b",     256'(mul_b),     256'd0);

    exp_prev = '0;
    for (int k = 0; k < NVEC; k++) begin
      run_op(vecs[k].va, vecs[k].vb, -1, dc, msc, bc, pr, hd);
      check($sformatf("vec%0d product", k),   pr,          vecs[k].vexp);
      check($sformatf("vec%0d done_cyc", k),  256'(dc),    256'(LIMBS*LIMBS + MUL_LAT + 1));
      check($sformatf("vec%0d mul_starts", k), 256'(msc),  256'(LIMBS*LIMBS));
      check($sformatf("vec%0d busy_cycles", k), 256'(bc),  256'(LIMBS*LIMBS + MUL_LAT));
      if (k > 0) check($sformatf("vec%0d product_hold", k), hd, exp_prev);
      exp_prev = vecs[k].vexp;
    end
    check("idle mul_a after done", 256'(mul_a), 256'd0);

    // Start while busy is ignored; the next start right after FIN is taken.
    run_op(128'd3, 128'd5, 5, dc, msc, bc, pr, hd);
    check("busy-start product",  pr,       256'd15);
    check("busy-start done_cyc", 256'(dc), 256'd19);
    check("busy-start mul_starts", 256'(msc), 256'd16);
    run_op(128'd7, 128'd7, -1, dc, msc, bc, pr, hd);
    check("post-fin product",  pr,       256'd49);
    check("post-fin done_cyc", 256'(dc), 256'd19);
    check("post-fin hold",     hd,       256'd15);

    // Reset in the middle of an operation.
    @(negedge clk);
    start     = 1'b1;
    a         = 128'd11;
    b         = 128'd13;
    done_seen = 0;
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (c == 10) rst = 1'b1;
      if (c == 11) begin
        rst = 1'b0;
        check("midrst busy",      256'(busy),      256'd0);
        check("midrst done",      256'(done),      256'd0);
        check("midrst product",   product,         256'd0);
        check("midrst mul_start", 256'(mul_start), 256'd0);
      end
      if (done) done_seen++;
    end
    check("midrst no done", 256'(done_seen), 256'd0);
    run_op(128'd3, 128'd5, -1, dc, msc, bc, pr, hd);
    check("after-rst product",  pr,       256'd15);
    check("after-rst done_cyc", 256'(dc), 256'd19);

    // Back-to-back random operations with start held high.
    @(negedge clk);
    ra    = {$urandom(), $urandom(), $urandom(), $urandom()};
    rb    = {$urandom(), $urandom(), $urandom(), $urandom()};
    a     = ra;
    b     = rb;
    start = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      rexp = 256'(ra) * 256'(rb);
      gap  = -1;
      for (int c = 1; c <= 40; c++) begin
        @(negedge clk);
        if (done) begin
          gap = c;
          break;
        end
      end
      check($sformatf("rand%0d product", k), product, rexp);
      check($sformatf("rand%0d spacing", k), 256'(gap), (k == 0) ? 256'd19 : 256'd20);
      if (gap < 0) break;
      ra = {$urandom(), $urandom(), $urandom(), $urandom()};
      rb = {$urandom(), $urandom(), $urandom(), $urandom()};
      if (k % 10 == 3) ra = {128{1'b1}};
      a = ra;
      b = rb;
    end
    start = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/limb_mul_sequencer.md
# limb_mul_sequencer

Multi-precision multiplier controller that builds an N-limb × N-limb product out of a single W×W pipelined DSP multiplier. It sits directly upstream of the DSP multiplier and also consumes its output. It splits latched wide operands into W-bit limbs, issues one limb pair per cycle, and accumulates the shifted partial products into a 2·W·LIMBS-bit result. It is the wide-multiply front end for the modular-arithmetic datapath.

## Interface
- W, 32: limb width; must equal the multiplier width.
- LIMBS, 4: limbs per operand, ≥1; operand width N = W·LIMBS.
- MUL_LAT, 2: fixed multiplier latency in cycles, from the mul_start cycle to the cycle its mul_product is valid.

- clk  in  1: single clock; all logic on posedge.
- rst  in  1: synchronous, active-high reset.
- start  in  1: request; sampled only when busy=0.
- a  in  N: operand A, captured on an accepted start.
- b  in  N: operand B, captured on an accepted start.
- busy  out  1: high from the cycle after an accepted start through the last accumulate cycle.
- product  out  2N: A·B, held stable from the done cycle until the next done.
- done  out  1: single-cycle completion pulse.
- mul_start  out  1: issue strobe to the multiplier.
- mul_a  out  W: limb of A for the multiplier.
- mul_b  out  W: limb of B for the multiplier.
- mul_product  in  2W: multiplier result. The multiplier's own done flag is not used.

## Operation
- Reset values: busy=0, done=0, product=0, mul_start=0, mul_a=0, mul_b=0. State=IDLE, accumulator=0, all issue-pipeline valid bits=0.
- FSM states:
  - IDLE: accept when start=1. Latch a and b, clear the accumulator, set i=j=0, go to ISSUE.
  - ISSUE: each cycle drive mul_start=1, mul_a=A[i], mul_b=B[j], where limb k occupies bits [W·k+W-1 : W·k]. Order is i outer, j inner, each 0..LIMBS-1. After the (LIMBS²)th issue, go to DRAIN.
  - DRAIN: mul_start=0. Wait until the issue pipeline is empty.
  - FIN: one cycle. Assert done and copy the accumulator into product. Go to IDLE.
- Tag pipeline: a MUL_LAT-deep shift register carrying {valid, s=i+j} alongside each issue. When valid reaches the end of the pipeline, add mul_product << (W·s) to the accumulator.
- Arithmetic: the accumulator is 2N bits and unsigned. Partial sums never exceed (2^N−1)², so no carry out of bit 2N−1 occurs and none is kept.
- mul_a and mul_b are driven only in ISSUE (registered). Their values outside ISSUE are don't-care but are held at 0.
- start while busy=1 is ignored; it is not queued.
- start is accepted in the FIN cycle only after FIN completes, i.e. in the following IDLE cycle. busy is 0 in the FIN cycle.
- rst at any time aborts the operation and restores all reset values. Any in-flight tags are discarded. No done pulse follows.
- LIMBS=1: a single issue, otherwise identical flow.

## Timing
- start high in cycle 0 (IDLE) → first mul_start in cycle 1, last mul_start in cycle LIMBS².
- Issue at cycle t is accumulated at the end of cycle t+MUL_LAT.
- done high in cycle LIMBS²+MUL_LAT+1, and product is valid in that same cycle. For defaults this is cycle 19.
- busy high from cycle 1 through cycle LIMBS²+MUL_LAT.
- Throughput: one wide product per LIMBS²+MUL_LAT+2 cycles when start is held high.
- mul_start is high for exactly LIMBS² consecutive cycles per operation.

## Test plan
- Basic: a=3, b=5 (defaults), start one cycle → done in cycle 19, product=15. Exactly 16 mul_start cycles observed.
- Limb crossing: a=2^32, b=2^96+1 → product=2^128+2^32. Checks shift indexing for s=1 and s=4.
- Worst case: a=b=2^128−1 → product=2^256−2^129+1. No overflow.
- Busy start: second start with a=7, b=7 in cycle 5 → ignored; first result unchanged. A start in cycle 20 → new done in cycle 39, product=49.
- Reset mid-op: rst in cycle 10 → busy=0, done=0, product=0 next cycle, and no done ever appears. A fresh start then completes normally.
- Random: 1000 random a,b with start held high → every product matches the reference model A·B. done spacing is 20 cycles.
